mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter sharing the single LC-3b memory port between the instruction-fetch path and the data (LDx/STx) path of the control FSM. Each requester holds its request until it receives a one-cycle ready pulse, which is the R input the control FSM waits on in its memory states. The block latches address and write data at grant, drives the memory for a fixed number of cycles, captures read data, and alternates fairly between requesters under contention.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MEM_LATENCY, 4, cycles the memory must see a stable access (min 1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request, held until if_rdy
- if_addr  in  ADDR_W  fetch address (read only)
- dt_req  in  1  data request, held until dt_rdy
- dt_we  in  1  data write enable (1 = store)
- dt_wmask  in  2  byte lanes for store ([0] low byte, [1] high byte)
- dt_addr  in  ADDR_W  data address
- dt_wdata  in  DATA_W  store data
- if_rdy  out  1  one-cycle pulse, fetch complete (R to FSM)
- dt_rdy  out  1  one-cycle pulse, data access complete (R to FSM)
- rdata  out  DATA_W  captured read data, shared by both requesters
- busy  out  1  high in BUSY and DONE
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_wmask  out  2  memory byte-lane mask
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last BUSY cycle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req high at the clock edge, pick a winner, latch its addr/we/wmask/wdata, set grant, load counter = MEM_LATENCY-1, go BUSY. No req: stay.
- Arbitration: single requester wins outright; both high → grant the one not granted last (round-robin). last_grant resets to data, so first tie goes to fetch.
- Fetch grant forces we=0, wmask=00.
- BUSY: mem_en=1, mem_we=latched we, address/data from latched registers (requester input changes ignored). Counter decrements each cycle; at 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
- DONE: assert granted requester's rdy for exactly one cycle, mem_en=0, go IDLE, update last_grant.
- Requester must drop req the cycle after rdy; req high in IDLE afterward is a new request. A non-granted requester waits with req held; no request is dropped.
- Reset (any time, including mid-BUSY): state IDLE, all outputs 0, rdata=0, counter=0, last_grant=data; in-flight access abandoned, mem_we deasserts immediately.

## Timing
- Req first seen in IDLE at cycle 0 → BUSY cycles 1..MEM_LATENCY → rdy and new rdata in cycle MEM_LATENCY+1 (cycle 5 with default).
- Back-to-back: earliest next grant at the IDLE cycle after DONE; per-access occupancy MEM_LATENCY+2 cycles.
- Waiting requester under contention: served at most one transaction later.
- rdy pulses never overlap; if_rdy and dt_rdy mutually exclusive.
- mem_* outputs registered; no combinational path from req inputs to mem_* or rdy.
- MEM_LATENCY=1: single BUSY cycle, rdy in cycle 2.

## Structure
- Shared package: state encoding (IDLE/BUSY/DONE), grant index constants (GNT_IF, GNT_DT), default MEM_LATENCY.
- One sub-module natural: mem_rr_pick, combinational 2-way round-robin picker (reqs, last_grant → grant).
- Counter width ceil(log2(MEM_LATENCY))+1.

## Test plan
- Reset then if_req=1, if_addr=0x3000, mem_rdata=0x1234 → mem_en cycles 1–4, if_rdy pulse cycle 5, rdata=0x1234, busy low cycle 6.
- Store dt_we=1, dt_wmask=01, dt_addr=0x4001, dt_wdata=0x00AB → mem_we=1, mem_wmask=01 cycles 1–4, dt_rdy cycle 5, rdata unchanged.
- Both req high from reset → fetch served first (if_rdy cycle 5), data granted cycle 6, dt_rdy cycle 11; repeat tie → fetch then data alternate.
- Change dt_addr 0x4000→0x5000 during BUSY → mem_addr stays 0x4000 throughout.
- Reset asserted mid-BUSY (cycle 3) → all outputs 0 same cycle, no rdy; after release, new if_req completes normally in MEM_LATENCY+1 cycles.
- MEM_LATENCY=1 build, fetch → mem_en cycle 1 only, if_rdy cycle 2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and grant constants for mem_arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DT = 1'b1;

   localparam int DEF_MEM_LATENCY = 4;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational 2-way round-robin picker (fetch vs data)
module mem_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic if_req,
   input  logic dt_req,
   input  logic last_grant,
   output logic any_req,
   output logic grant
);

   always_comb begin
      any_req = if_req | dt_req;
      if (if_req && dt_req) begin
         grant = ~last_grant;
      end else if (dt_req) begin
         grant = GNT_DT;
      end else begin
         grant = GNT_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              dt_req,
   input  logic              dt_we,
   input  logic [1:0]        dt_wmask,
   input  logic [ADDR_W-1:0] dt_addr,
   input  logic [DATA_W-1:0] dt_wdata,
   output logic              if_rdy,
   output logic              dt_rdy,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [1:0]        mem_wmask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              gnt_q;
   logic              last_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        wmask_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              any_req;
   logic              pick;
   logic              in_busy;

   mem_rr_pick u_pick (
      .if_req     (if_req),
      .dt_req     (dt_req),
      .last_grant (last_q),
      .any_req    (any_req),
      .grant      (pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_BUSY;
         ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Requester inputs are only looked at in IDLE; everything after grant runs off the latched copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         gnt_q   <= GNT_IF;
         last_q  <= GNT_DT;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wmask_q <= 2'b00;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_q <= pick;
                  cnt_q <= CNT_LOAD;
                  if (pick == GNT_IF) begin
                     addr_q  <= if_addr;
                     we_q    <= 1'b0;
                     wmask_q <= 2'b00;
                     wdata_q <= '0;
                  end else begin
                     addr_q  <= dt_addr;
                     we_q    <= dt_we;
                     wmask_q <= dt_wmask;
                     wdata_q <= dt_wdata;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  if (!we_q) rdata_q <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: last_q <= gnt_q;
            default: ;
         endcase
      end
   end

   // Outputs decode only registered state, so reset clears them in the same cycle.
   always_comb begin
      in_busy   = (state_q == ST_BUSY);
      mem_en    = in_busy;
      mem_we    = in_busy & we_q;
      mem_wmask = in_busy ? wmask_q : 2'b00;
      mem_addr  = in_busy ? addr_q : '0;
      mem_wdata = in_busy ? wdata_q : '0;
      if_rdy    = (state_q == ST_DONE) && (gnt_q == GNT_IF);
      dt_rdy    = (state_q == ST_DONE) && (gnt_q == GNT_DT);
      busy      = (state_q != ST_IDLE);
      rdata     = rdata_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        dt_req = 1'b0;
   logic        dt_we = 1'b0;
   logic [1:0]  dt_wmask = '0;
   logic [15:0] dt_addr = '0;
   logic [15:0] dt_wdata = '0;
   logic        if_rdy, dt_rdy, busy, mem_en, mem_we;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_wmask;

   logic        s_if_req = 1'b0;
   logic [15:0] s_if_addr = '0;
   logic [15:0] s_mem_rdata = '0;
   logic        s_zero1 = 1'b0;
   logic [1:0]  s_zero2 = '0;
   logic [15:0] s_zero16 = '0;
   logic        s_if_rdy, s_dt_rdy, s_busy, s_mem_en, s_mem_we;
   logic [15:0] s_rdata, s_mem_addr, s_mem_wdata;
   logic [1:0]  s_mem_wmask;

   logic        use_dev = 1'b0;
   logic        dev_init = 1'b0;
   logic [15:0] fixed_rdata = '0;
   logic [15:0] dev_mem [16];
   logic [15:0] init_mem [16];
   logic [15:0] ref_mem [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
      .dt_req(dt_req), .dt_we(dt_we), .dt_wmask(dt_wmask), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
      .if_rdy(if_rdy), .dt_rdy(dt_rdy), .rdata(rdata), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .if_req(s_if_req), .if_addr(s_if_addr),
      .dt_req(s_zero1), .dt_we(s_zero1), .dt_wmask(s_zero2), .dt_addr(s_zero16), .dt_wdata(s_zero16),
      .if_rdy(s_if_rdy), .dt_rdy(s_dt_rdy), .rdata(s_rdata), .busy(s_busy),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_wmask(s_mem_wmask), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
   );

   assign mem_rdata = use_dev ? dev_mem[mem_addr[3:0]] : fixed_rdata;

   // Memory device: applies byte-masked writes on every cycle the store is presented.
   always @(posedge clk) begin
      if (dev_init) begin
         for (int i = 0; i < 16; i++) dev_mem[i] <= init_mem[i];
      end else if (use_dev && mem_en && mem_we) begin
         if (mem_wmask[0]) dev_mem[mem_addr[3:0]][7:0]  <= mem_wdata[7:0];
         if (mem_wmask[1]) dev_mem[mem_addr[3:0]][15:8] <= mem_wdata[15:8];
      end
   end

   task automatic do_reset;
      reset = 1'b1;
      if_req = 1'b0; dt_req = 1'b0; dt_we = 1'b0; dt_wmask = 2'b00;
      s_if_req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({if_rdy, dt_rdy, busy, mem_en, mem_we, mem_wmask} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0", {if_rdy, dt_rdy, busy, mem_en, mem_we, mem_wmask});
      end
      checks++;
      if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
         errors++; $display("FAIL reset_data got %h exp 0", {rdata, mem_addr, mem_wdata});
      end
   endtask

   task automatic test_fetch;
      use_dev = 1'b0; fixed_rdata = 16'h1234; if_addr = 16'h3000; if_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_en !== (c <= 4)) begin errors++; $display("FAIL fetch_mem_en c=%0d got %b exp %b", c, mem_en, (c <= 4)); end
         checks++;
         if (if_rdy !== (c == 5) || dt_rdy !== 1'b0) begin errors++; $display("FAIL fetch_rdy c=%0d got %b%b exp %b0", c, if_rdy, dt_rdy, (c == 5)); end
         checks++;
         if (busy !== (c <= 5)) begin errors++; $display("FAIL fetch_busy c=%0d got %b exp %b", c, busy, (c <= 5)); end
         if (c <= 4) begin
            checks++;
            if (mem_addr !== 16'h3000 || mem_we !== 1'b0 || mem_wmask !== 2'b00) begin
               errors++; $display("FAIL fetch_mem c=%0d got %h/%b/%b exp 3000/0/00", c, mem_addr, mem_we, mem_wmask);
            end
         end
         if (c == 5) begin
            checks++;
            if (rdata !== 16'h1234) begin errors++; $display("FAIL fetch_rdata got %h exp 1234", rdata); end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_store;
      fixed_rdata = 16'hFFFF;
      dt_req = 1'b1; dt_we = 1'b1; dt_wmask = 2'b01; dt_addr = 16'h4001; dt_wdata = 16'h00AB;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_en !== (c <= 4) || mem_we !== (c <= 4)) begin errors++; $display("FAIL store_en_we c=%0d got %b%b exp %b", c, mem_en, mem_we, (c <= 4)); end
         if (c <= 4) begin
            checks++;
            if (mem_wmask !== 2'b01 || mem_addr !== 16'h4001 || mem_wdata !== 16'h00AB) begin
               errors++; $display("FAIL store_mem c=%0d got %b/%h/%h exp 01/4001/00ab", c, mem_wmask, mem_addr, mem_wdata);
            end
         end
         checks++;
         if (dt_rdy !== (c == 5) || if_rdy !== 1'b0) begin errors++; $display("FAIL store_rdy c=%0d got %b%b exp 0%b", c, if_rdy, dt_rdy, (c == 5)); end
         checks++;
         if (rdata !== 16'h1234) begin errors++; $display("FAIL store_rdata c=%0d got %h exp 1234", c, rdata); end
         if (c == 2) begin dt_wdata = 16'hFFFF; dt_wmask = 2'b10; end
         if (c == 5) begin dt_req = 1'b0; dt_we = 1'b0; end
      end
   endtask

   task automatic test_addr_hold;
      fixed_rdata = 16'hBEEF;
      dt_req = 1'b1; dt_we = 1'b0; dt_addr = 16'h4000;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c <= 4) begin
            checks++;
            if (mem_addr !== 16'h4000 || mem_en !== 1'b1) begin errors++; $display("FAIL hold_addr c=%0d got %h/%b exp 4000/1", c, mem_addr, mem_en); end
         end
         if (c == 1) dt_addr = 16'h5000;
         if (c == 5) begin
            checks++;
            if (dt_rdy !== 1'b1 || rdata !== 16'hBEEF) begin errors++; $display("FAIL hold_done got %b/%h exp 1/beef", dt_rdy, rdata); end
            dt_req = 1'b0;
         end
      end
   endtask

   task automatic test_tie;
      logic exp_en;
      do_reset();
      fixed_rdata = 16'hC0DE;
      if_addr = 16'h3100; dt_addr = 16'h4100; dt_we = 1'b0;
      if_req = 1'b1; dt_req = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         exp_en = ((c - 1) % 6) < 4;
         checks++;
         if (if_rdy !== (c == 5 || c == 17) || dt_rdy !== (c == 11 || c == 23)) begin
            errors++; $display("FAIL tie_rdy c=%0d got %b%b", c, if_rdy, dt_rdy);
         end
         checks++;
         if (mem_en !== exp_en) begin errors++; $display("FAIL tie_en c=%0d got %b exp %b", c, mem_en, exp_en); end
         if (exp_en) begin
            checks++;
            if (mem_addr !== ((((c - 1) / 6) % 2 == 0) ? 16'h3100 : 16'h4100)) begin
               errors++; $display("FAIL tie_addr c=%0d got %h", c, mem_addr);
            end
         end
         if (c == 5 || c == 17) if_req = 1'b0;
         if (c == 11 || c == 23) dt_req = 1'b0;
         if (c == 12) begin if_req = 1'b1; dt_req = 1'b1; end
      end
   endtask

   task automatic test_reset_mid;
      dt_req = 1'b1; dt_we = 1'b1; dt_wmask = 2'b11; dt_addr = 16'h4200; dt_wdata = 16'h55AA;
      for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got %b exp 1", mem_we); end
      reset = 1'b1;
      #1;
      checks++;
      if ({if_rdy, dt_rdy, busy, mem_en, mem_we, mem_wmask} !== 7'b0 || {rdata, mem_addr, mem_wdata} !== 48'h0) begin
         errors++; $display("FAIL mid_reset got %b %h exp 0", {if_rdy, dt_rdy, busy, mem_en, mem_we, mem_wmask}, {rdata, mem_addr, mem_wdata});
      end
      dt_req = 1'b0; dt_we = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      fixed_rdata = 16'h5A5A; if_addr = 16'h3000; if_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         checks++;
         if (if_rdy !== (c == 5) || dt_rdy !== 1'b0 || mem_en !== (c <= 4)) begin
            errors++; $display("FAIL mid_after c=%0d got rdy=%b%b en=%b", c, if_rdy, dt_rdy, mem_en);
         end
         if (c == 5) begin
            checks++;
            if (rdata !== 16'h5A5A) begin errors++; $display("FAIL mid_rdata got %h exp 5a5a", rdata); end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_latency1;
      s_mem_rdata = 16'h1111; s_if_addr = 16'h3000; s_if_req = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (s_mem_en !== (c == 1) || s_if_rdy !== (c == 2) || s_dt_rdy !== 1'b0 || s_busy !== (c <= 2)) begin
            errors++; $display("FAIL lat1 c=%0d got en=%b rdy=%b%b busy=%b", c, s_mem_en, s_if_rdy, s_dt_rdy, s_busy);
         end
         if (c == 1) begin
            checks++;
            if (s_mem_addr !== 16'h3000 || s_mem_we !== 1'b0 || s_mem_wmask !== 2'b00 || s_mem_wdata !== 16'h0) begin
               errors++; $display("FAIL lat1_mem got %h/%b/%b/%h", s_mem_addr, s_mem_we, s_mem_wmask, s_mem_wdata);
            end
         end
         if (c == 2) begin
            checks++;
            if (s_rdata !== 16'h1111) begin errors++; $display("FAIL lat1_rdata got %h exp 1111", s_rdata); end
            s_if_req = 1'b0;
         end
      end
   endtask

   // Reference: one access at a time, grant decided in an idle cycle, rdy exactly L+1 cycles later.
   task automatic test_random;
      logic [1:0]  pend;
      logic        act, who, last, in_busy, in_done;
      int          g, d;
      logic [15:0] ex_addr, ex_wdata, ex_rd, exp_rd;
      logic        ex_we;
      logic [1:0]  ex_mask;
      for (int i = 0; i < 16; i++) begin
         init_mem[i] = 16'($urandom);
         ref_mem[i] = init_mem[i];
      end
      use_dev = 1'b1; dev_init = 1'b1;
      @(posedge clk); #1;
      dev_init = 1'b0;
      do_reset();
      pend = 2'b00; act = 1'b0; who = 1'b0; last = 1'b1; g = -10; d = -1;
      exp_rd = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0; ex_we = 1'b0; ex_mask = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         in_busy = act && c > g && c < d;
         in_done = act && c == d;
         if (in_done && !ex_we) exp_rd = ex_rd;
         checks++;
         if (mem_en !== in_busy || busy !== (in_busy || in_done)) begin
            errors++; $display("FAIL rnd_en c=%0d got en=%b busy=%b exp %b/%b", c, mem_en, busy, in_busy, in_busy || in_done);
         end
         checks++;
         if (if_rdy !== (in_done && who == 1'b0) || dt_rdy !== (in_done && who == 1'b1)) begin
            errors++; $display("FAIL rnd_rdy c=%0d got %b%b done=%b who=%b", c, if_rdy, dt_rdy, in_done, who);
         end
         checks++;
         if (rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, rdata, exp_rd); end
         if (in_busy) begin
            checks++;
            if (mem_addr !== ex_addr || mem_we !== ex_we || mem_wmask !== ex_mask || (ex_we && mem_wdata !== ex_wdata)) begin
               errors++; $display("FAIL rnd_mem c=%0d got %h/%b/%b/%h exp %h/%b/%b/%h", c, mem_addr, mem_we, mem_wmask, mem_wdata, ex_addr, ex_we, ex_mask, ex_wdata);
            end
         end
         if (in_done) begin
            pend[who] = 1'b0; last = who; act = 1'b0;
            if (who == 1'b0) if_req = 1'b0; else dt_req = 1'b0;
         end
         if (!pend[0] && !(in_done && who == 1'b0) && $urandom_range(0, 2) == 0) begin
            pend[0] = 1'b1; if_req = 1'b1; if_addr = 16'($urandom);
         end
         if (!pend[1] && !(in_done && who == 1'b1) && $urandom_range(0, 2) == 0) begin
            pend[1] = 1'b1; dt_req = 1'b1; dt_we = 1'($urandom); dt_wmask = 2'($urandom);
            dt_addr = 16'($urandom); dt_wdata = 16'($urandom);
         end
         if (act && c > g && c < d) begin
            if (who == 1'b0) if_addr = 16'($urandom);
            else begin dt_addr = 16'($urandom); dt_wdata = 16'($urandom); dt_we = 1'($urandom); dt_wmask = 2'($urandom); end
         end
         if (!act && c > d && pend != 2'b00) begin
            who = (pend == 2'b11) ? ~last : pend[1];
            g = c; d = c + L + 1; act = 1'b1;
            if (who == 1'b0) begin
               ex_addr = if_addr; ex_we = 1'b0; ex_mask = 2'b00; ex_wdata = '0;
               ex_rd = ref_mem[if_addr[3:0]];
            end else begin
               ex_addr = dt_addr; ex_we = dt_we; ex_mask = dt_wmask; ex_wdata = dt_wdata;
               ex_rd = ref_mem[dt_addr[3:0]];
               if (dt_we) begin
                  if (dt_wmask[0]) ref_mem[dt_addr[3:0]][7:0]  = dt_wdata[7:0];
                  if (dt_wmask[1]) ref_mem[dt_addr[3:0]][15:8] = dt_wdata[15:8];
               end
            end
         end
      end
      if_req = 1'b0; dt_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_addr_hold();
      test_tie();
      test_reset_mid();
      test_latency1();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
